// File: rtl/move_collector_pkg.sv
// ----------------------------------------------------------------------------
// move_collector_pkg : shared chess constants, move-record width, FSM types
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package move_collector_pkg;

   localparam logic WHITE = 1'b0;
   localparam logic BLACK = 1'b1;

   typedef enum logic [2:0] {
      EMPTY  = 3'd0,
      PAWN   = 3'd1,
      KNIGHT = 3'd2,
      BISHOP = 3'd3,
      ROOK   = 3'd4,
      QUEEN  = 3'd5,
      KING   = 3'd6
   } piece_t;

   localparam logic [2:0] ROW1 = 3'd0;
   localparam logic [2:0] ROW2 = 3'd1;
   localparam logic [2:0] ROW3 = 3'd2;
   localparam logic [2:0] ROW4 = 3'd3;
   localparam logic [2:0] ROW5 = 3'd4;
   localparam logic [2:0] ROW6 = 3'd5;
   localparam logic [2:0] ROW7 = 3'd6;
   localparam logic [2:0] ROW8 = 3'd7;

   localparam logic [2:0] COLA = 3'd0;
   localparam logic [2:0] COLB = 3'd1;
   localparam logic [2:0] COLC = 3'd2;
   localparam logic [2:0] COLD = 3'd3;
   localparam logic [2:0] COLE = 3'd4;
   localparam logic [2:0] COLF = 3'd5;
   localparam logic [2:0] COLG = 3'd6;
   localparam logic [2:0] COLH = 3'd7;

   // Square is {row, col}; bit 6 set marks "no square".
   localparam logic [6:0] PVOID = 7'h40;

   localparam int MOVE_DW = 160;

   typedef logic [2:0] col_t;

   typedef enum logic [1:0] {
      SCAN    = 2'd0,
      LATCH   = 2'd1,
      PRESENT = 2'd2
   } state_t;

   function automatic col_t next_col(input col_t c);
      return c + col_t'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/move_collector_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter_8 : first requester at or after ptr_i (mod 8), one-hot + index
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_8
   import move_collector_pkg::*;
(
   input  logic [7:0] req_i,
   input  col_t       ptr_i,
   output logic [7:0] grant_o,
   output col_t       idx_o,
   output logic       valid_o
);

   col_t w_pos;

   always_comb begin
      w_pos   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int k = 0; k < 8; k++) begin
         w_pos = ptr_i + col_t'(k);
         if (!valid_o && req_i[w_pos]) begin
            valid_o = 1'b1;
            idx_o   = w_pos;
         end
      end
      grant_o = valid_o ? (8'b1 << idx_o) : 8'b0;
   end

endmodule

`default_nettype wire

// File: rtl/move_collector.sv
// ----------------------------------------------------------------------------
// move_collector : round-robin drain of the column move FIFOs into one stream
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module move_collector
   import move_collector_pkg::*;
#(
   parameter int NCOL = 8,
   parameter int DW   = MOVE_DW,
   parameter int CW   = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [NCOL*DW-1:0] colFifoOut,
   input  logic [NCOL-1:0]   colFifoEmpty,
   input  logic [NCOL-1:0]   colDone,
   output logic [NCOL-1:0]   colRden,
   output logic [DW-1:0]     moveOut,
   output logic [2:0]        moveCol,
   output logic              moveValid,
   input  logic              moveReady,
   output logic [CW-1:0]     moveCount,
   output logic              allDone
);

   state_t        state_q;
   col_t          rrPtr_q;
   col_t          col_q;
   logic [DW-1:0] moveOut_q;
   col_t          moveCol_q;
   logic          moveValid_q;
   logic [CW-1:0] moveCount_q;
   logic          allDone_q;

   logic [NCOL-1:0] w_grant;
   col_t            w_idx;
   logic            w_found;

   logic [DW-1:0]   moveOut_d;
   logic [CW-1:0]   moveCount_d;
   logic            allDone_d;

   rr_arbiter_8 u_arb (
      .req_i   (~colFifoEmpty),
      .ptr_i   (rrPtr_q),
      .grant_o (w_grant),
      .idx_o   (w_idx),
      .valid_o (w_found)
   );

   // The pop must happen in the same cycle the empty flag was seen low,
   // so the read enable is decoded straight from the scan result.
   assign colRden = (state_q == SCAN) ? w_grant : '0;

   assign moveOut_d   = colFifoOut[col_q*DW +: DW];
   assign moveCount_d = (&moveCount_q) ? moveCount_q : moveCount_q + CW'(1);
   assign allDone_d   = (&colDone) & (&colFifoEmpty) &
                        (state_q == SCAN) & ~moveValid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         rrPtr_q     <= '0;
         col_q       <= '0;
         moveOut_q   <= '0;
         moveCol_q   <= '0;
         moveValid_q <= 1'b0;
         moveCount_q <= '0;
         allDone_q   <= 1'b0;
      end else begin
         allDone_q <= allDone_d;
         case (state_q)
            SCAN: begin
               if (w_found) begin
                  col_q   <= w_idx;
                  state_q <= LATCH;
               end
            end
            LATCH: begin
               moveOut_q   <= moveOut_d;
               moveCol_q   <= col_q;
               moveValid_q <= 1'b1;
               state_q     <= PRESENT;
            end
            PRESENT: begin
               // Restarting past the served column keeps a busy FIFO from
               // starving its neighbours.
               if (moveReady) begin
                  moveValid_q <= 1'b0;
                  moveCount_q <= moveCount_d;
                  rrPtr_q     <= next_col(col_q);
                  state_q     <= SCAN;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign moveOut   = moveOut_q;
   assign moveCol   = moveCol_q;
   assign moveValid = moveValid_q;
   assign moveCount = moveCount_q;
   assign allDone   = allDone_q;

endmodule

`default_nettype wire

// File: tb/tb_move_collector.sv
// ----------------------------------------------------------------------------
// tb_move_collector : column FIFO models, round-robin reference, scenario tasks
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_move_collector;

   localparam int NCOL = 8;
   localparam int DW   = 160;
   localparam int CW   = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [NCOL*DW-1:0] colFifoOut;
   logic [NCOL-1:0]    colFifoEmpty;
   logic [NCOL-1:0]    colDone;
   logic [NCOL-1:0]    colRden;
   logic [DW-1:0]      moveOut;
   logic [2:0]         moveCol;
   logic               moveValid;
   logic               moveReady;
   logic [CW-1:0]      moveCount;
   logic               allDone;

   move_collector #(.NCOL(NCOL), .DW(DW), .CW(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .colFifoOut   (colFifoOut),
      .colFifoEmpty (colFifoEmpty),
      .colDone      (colDone),
      .colRden      (colRden),
      .moveOut      (moveOut),
      .moveCol      (moveCol),
      .moveValid    (moveValid),
      .moveReady    (moveReady),
      .moveCount    (moveCount),
      .allDone      (allDone)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Column FIFOs: 1-cycle read latency, head owned here, tail by the tasks.
   logic [DW-1:0] fmem [8][64];
   int            fh [8];
   int            ft [8];

   for (genvar g = 0; g < NCOL; g++) begin : g_empty
      assign colFifoEmpty[g] = (fh[g] == ft[g]);
   end

   initial colFifoOut = '0;

   always @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCOL; c++) fh[c] <= 0;
         colFifoOut <= '0;
      end else begin
         for (int c = 0; c < NCOL; c++) begin
            if (colRden[c]) begin
               colFifoOut[c*DW +: DW] <= fmem[c][fh[c] % 64];
               fh[c] <= fh[c] + 1;
            end
         end
      end
   end

   int rden_viol   = 0;
   int rden_pulses = 0;

   always @(posedge clk) begin : mon
      int v;
      v = 0;
      if (!reset) begin
         if ($countones(colRden) > 1) v = v + 1;
         for (int c = 0; c < NCOL; c++)
            if (colRden[c] && fh[c] == ft[c]) v = v + 1;
         rden_viol <= rden_viol + v;
         if (|colRden) rden_pulses <= rden_pulses + 1;
      end
   end

   // Reference model: per-column word lists plus a round-robin pointer.
   logic [DW-1:0] mm [8][64];
   int            mh [8];
   int            mt [8];
   int            model_ptr   = 0;
   int            model_count = 0;
   int            exp_col[$];
   logic [DW-1:0] exp_word[$];

   function automatic logic [DW-1:0] rword();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push(input int c, input logic [DW-1:0] w);
      fmem[c][ft[c] % 64] = w;
      ft[c] = ft[c] + 1;
      mm[c][mt[c] % 64] = w;
      mt[c] = mt[c] + 1;
   endtask

   task automatic build_expected();
      bit any;
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         for (int k = 0; k < NCOL; k++) begin
            int c;
            c = (model_ptr + k) % NCOL;
            if (!any && mh[c] != mt[c]) begin
               exp_col.push_back(c);
               exp_word.push_back(mm[c][mh[c] % 64]);
               mh[c] = mh[c] + 1;
               model_ptr = (c + 1) % NCOL;
               any = 1'b1;
            end
         end
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < NCOL; c++) begin
         ft[c] = 0;
         mh[c] = 0;
         mt[c] = 0;
      end
      model_ptr   = 0;
      model_count = 0;
      exp_col.delete();
      exp_word.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      moveReady = 1'b0;
      colDone   = '0;
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain(input int ready_pct, input int budget);
      int cyc;
      cyc = 0;
      while (exp_col.size() > 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         n_cmp++;
         if (allDone !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_alldone: got %b want 0 with %0d moves pending", allDone, exp_col.size());
         end
         moveReady = ($urandom_range(99) < ready_pct);
         if (moveValid && moveReady) begin
            n_cmp++;
            if (moveCol !== 3'(exp_col[0])) begin
               n_bad++;
               $display("FAIL drain_col: got %0d want %0d", moveCol, exp_col[0]);
            end
            n_cmp++;
            if (moveOut !== exp_word[0]) begin
               n_bad++;
               $display("FAIL drain_word: got %h want %h", moveOut, exp_word[0]);
            end
            void'(exp_col.pop_front());
            void'(exp_word.pop_front());
            model_count++;
         end
      end
      n_cmp++;
      if (exp_col.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d moves still pending want 0", exp_col.size());
         exp_col.delete();
         exp_word.delete();
      end
      @(negedge clk);
      moveReady = 1'b0;
      n_cmp++;
      if (moveCount !== CW'(model_count)) begin
         n_bad++;
         $display("FAIL drain_count: got %0d want %0d", moveCount, model_count);
      end
      n_cmp++;
      if (rden_viol != 0) begin
         n_bad++;
         $display("FAIL rden_protocol: got %0d violations want 0", rden_viol);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; moveReady = 1'b0; colDone = '0;
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_cmp++; if (colRden   !== '0)   begin n_bad++; $display("FAIL reset_rden: got %b want 0", colRden); end
      n_cmp++; if (moveValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", moveValid); end
      n_cmp++; if (moveOut   !== '0)   begin n_bad++; $display("FAIL reset_out: got %h want 0", moveOut); end
      n_cmp++; if (moveCol   !== 3'd0) begin n_bad++; $display("FAIL reset_col: got %0d want 0", moveCol); end
      n_cmp++; if (moveCount !== '0)   begin n_bad++; $display("FAIL reset_count: got %0d want 0", moveCount); end
      n_cmp++; if (allDone   !== 1'b0) begin n_bad++; $display("FAIL reset_alldone: got %b want 0", allDone); end
   endtask

   task automatic test_single();
      int p0;
      p0 = rden_pulses;
      push(3, 160'hA5);
      build_expected();
      #1;
      n_cmp++; if (colRden !== 8'b0000_1000) begin n_bad++; $display("FAIL single_rden: got %b want 00001000", colRden); end
      @(negedge clk);
      n_cmp++; if (colRden !== 8'h00) begin n_bad++; $display("FAIL single_rden_off: got %b want 0", colRden); end
      n_cmp++; if (moveValid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", moveValid); end
      @(negedge clk);
      n_cmp++; if (moveValid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", moveValid); end
      n_cmp++; if (moveOut !== 160'hA5) begin n_bad++; $display("FAIL single_out: got %h want a5", moveOut); end
      n_cmp++; if (moveCol !== 3'd3) begin n_bad++; $display("FAIL single_col: got %0d want 3", moveCol); end
      n_cmp++; if (rden_pulses - p0 != 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", rden_pulses - p0); end
      moveReady = 1'b1;
      @(negedge clk);
      moveReady = 1'b0;
      void'(exp_col.pop_front());
      void'(exp_word.pop_front());
      model_count++;
      n_cmp++; if (moveCount !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", moveCount); end
      n_cmp++; if (moveValid !== 1'b0) begin n_bad++; $display("FAIL single_drop: got %b want 0", moveValid); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         push(1, rword());
         push(2, rword());
         push(6, rword());
      end
      build_expected();
      drain(100, 100);
   endtask

   task automatic test_backpressure();
      int p0;
      int cyc;
      logic [DW-1:0] w_exp;
      int c_exp;
      push(5, rword());
      push(0, rword());
      build_expected();
      cyc = 0;
      while (!moveValid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++; if (moveValid !== 1'b1) begin n_bad++; $display("FAIL bp_wait: got valid %b want 1", moveValid); end
      p0    = rden_pulses;
      w_exp = exp_word[0];
      c_exp = exp_col[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if (moveValid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", moveValid); end
         n_cmp++; if (moveOut !== w_exp) begin n_bad++; $display("FAIL bp_out: got %h want %h", moveOut, w_exp); end
         n_cmp++; if (moveCol !== 3'(c_exp)) begin n_bad++; $display("FAIL bp_col: got %0d want %0d", moveCol, c_exp); end
         n_cmp++; if (colRden !== 8'h00) begin n_bad++; $display("FAIL bp_rden: got %b want 0", colRden); end
      end
      n_cmp++; if (rden_pulses != p0) begin n_bad++; $display("FAIL bp_pulses: got %0d want %0d", rden_pulses, p0); end
      moveReady = 1'b1;
      @(negedge clk);
      moveReady = 1'b0;
      void'(exp_col.pop_front());
      void'(exp_word.pop_front());
      model_count++;
      n_cmp++; if (moveCount !== CW'(model_count)) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", moveCount, model_count); end
      drain(50, 100);
   endtask

   task automatic test_wrap();
      do_reset();
      push(6, rword());
      build_expected();
      drain(100, 50);
      push(0, rword());
      push(7, rword());
      build_expected();
      drain(100, 50);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < NCOL; c++) begin
            int n;
            n = $urandom_range(3);
            for (int j = 0; j < n; j++) push(c, rword());
         end
         build_expected();
         drain(60, 600);
      end
   endtask

   task automatic test_completion();
      do_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (allDone !== 1'b0) begin n_bad++; $display("FAIL done_notall: got %b want 0", allDone); end
      colDone = 8'hFF;
      push(2, rword());
      push(4, rword());
      push(7, rword());
      build_expected();
      drain(70, 200);
      n_cmp++; if (allDone !== 1'b0) begin n_bad++; $display("FAIL done_early: got %b want 0", allDone); end
      @(negedge clk);
      n_cmp++; if (allDone !== 1'b1) begin n_bad++; $display("FAIL done_set: got %b want 1", allDone); end
      push(4, rword());
      build_expected();
      @(negedge clk);
      n_cmp++; if (allDone !== 1'b0) begin n_bad++; $display("FAIL done_clear: got %b want 0", allDone); end
      drain(100, 50);
      @(negedge clk);
      n_cmp++; if (allDone !== 1'b1) begin n_bad++; $display("FAIL done_reset: got %b want 1", allDone); end
   endtask

   task automatic test_reset_mid_present();
      int cyc;
      do_reset();
      push(5, rword());
      build_expected();
      drain(100, 50);
      push(6, rword());
      build_expected();
      cyc = 0;
      while (!moveValid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++; if (moveValid !== 1'b1) begin n_bad++; $display("FAIL rmp_wait: got valid %b want 1", moveValid); end
      reset = 1'b1;
      clear_model();
      @(negedge clk);
      n_cmp++; if (moveValid !== 1'b0) begin n_bad++; $display("FAIL rmp_valid: got %b want 0", moveValid); end
      n_cmp++; if (moveCount !== '0) begin n_bad++; $display("FAIL rmp_count: got %0d want 0", moveCount); end
      n_cmp++; if (allDone !== 1'b0) begin n_bad++; $display("FAIL rmp_alldone: got %b want 0", allDone); end
      n_cmp++; if (colRden !== 8'h00) begin n_bad++; $display("FAIL rmp_rden: got %b want 0", colRden); end
      reset = 1'b0;
      push(1, rword());
      push(7, rword());
      build_expected();
      drain(100, 50);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_random();
      test_completion();
      test_reset_mid_present();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/move_collector.md
Name: move_collector

Overview:
- Downstream of the eight columnUnit instances.
- Drains each column's move FIFO (fifoOut/fifoEmpty/rden) in round-robin order and serialises the moves into one valid/ready stream for the move-evaluation stage.
- Tags each move with its source column, counts the moves issued, and flags when the whole board's move generation is complete.

Parameters:
- NCOL, 8, number of column units drained (one per board file, COLA..COLH).
- DW, 160, width of one column FIFO word (opaque move record).
- CW, 16, width of the move counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- colFifoOut  in  NCOL*DW  concatenated column FIFO outputs; column c occupies bits [c*DW+DW-1 : c*DW].
- colFifoEmpty  in  NCOL  per-column FIFO empty flag.
- colDone  in  NCOL  per-column done flag; once high, it stays high until reset.
- colRden  out  NCOL  per-column FIFO read enable; at most one bit is high in any cycle.
- moveOut  out  DW  current move record.
- moveCol  out  3  source column of moveOut (COLA=0 .. COLH=7).
- moveValid  out  1  moveOut/moveCol valid.
- moveReady  in  1  consumer accepts the move when moveValid & moveReady.
- moveCount  out  CW  number of accepted moves since reset; saturates at all-ones.
- allDone  out  1  generation complete and the collector has drained.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - State = SCAN, rrPtr = 0, captured column = 0.
  - colRden = 0, moveOut = 0, moveCol = 0, moveValid = 0, moveCount = 0, allDone = 0.
- Column FIFO contract: a word is valid on colFifoOut the cycle after rden is high for that column (1-cycle read latency).
- FSM states: SCAN, LATCH, PRESENT.
- SCAN:
  - Search columns rrPtr, rrPtr+1, ... wrapping mod NCOL for the first column with colFifoEmpty = 0.
  - If a column c is found: colRden[c] = 1 this cycle (combinational from state and the empty flags), record c, go to LATCH.
  - If none is found: colRden = 0, stay in SCAN.
- LATCH:
  - colRden = 0.
  - At the clock edge, register colFifoOut slice c into moveOut and c into moveCol, set moveValid = 1, go to PRESENT.
- PRESENT:
  - Hold moveOut, moveCol and moveValid stable while moveReady = 0.
  - On moveValid & moveReady at the edge: moveValid = 0, moveCount += 1 (saturating at 2^CW-1), rrPtr = (c+1) mod NCOL, go to SCAN.
- Throughput and latency:
  - Best case is one move per 3 cycles.
  - Latency from rden to moveValid is 2 edges.
- Fairness: the search pointer always advances past the last-served column, so a column with a continuously non-empty FIFO cannot starve the others.
- Wrap: when c = 7 the next search starts at column 0.
- allDone:
  - Registered output.
  - Set to 1 when all colDone bits are 1, all colFifoEmpty bits are 1, the state is SCAN and moveValid = 0.
  - Cleared only by reset, or when any of those conditions drops.
- Simultaneous events:
  - A column becoming non-empty in the same cycle the search passes it is seen only if its empty flag is already low in that SCAN cycle; otherwise it is served on a later scan.
  - moveReady is ignored outside PRESENT.
- Reset mid-operation:
  - A word already popped (LATCH) or presented but not accepted (PRESENT) is discarded.
  - The FSM returns to SCAN and the counter clears.
  - The column units are reset by the same signal, so no stale words survive.
- Empty flag dropping: if colFifoEmpty[c] is 1 in the SCAN cycle, no rden is issued to column c; the block never reads an empty FIFO.

Decomposition:
- Shared chess package holds:
  - Colour constants WHITE/BLACK.
  - Piece codes EMPTY..KING.
  - Row constants ROW1..ROW8 and column constants COLA..COLH.
  - PVOID.
  - The DW = 160 move-record width.
- One natural sub-module: rr_arbiter_8 (combinational priority search from rrPtr over an 8-bit request vector, returning a one-hot grant and a 3-bit index).
- The FSM, output register and counter stay in move_collector.

Test Plan:
- Single move: column 3 non-empty with word 160'hA5. Required response:
  - colRden = 8'b0000_1000 for exactly one cycle.
  - moveValid rises 2 edges later with moveOut = 160'hA5, moveCol = 3.
  - With moveReady = 1, moveCount = 1.
- Round-robin: columns 1, 2 and 6 each hold 2 words with moveReady tied to 1. Required response:
  - moveCol sequence 1, 2, 6, 1, 2, 6.
  - moveCount = 6.
  - colRden is never high while the selected column's empty flag is high.
- Backpressure: moveReady = 0 for 10 cycles after moveValid. Required response:
  - moveOut and moveCol stay stable and moveValid stays 1.
  - No further colRden pulses.
  - After moveReady = 1, exactly one accept is counted.
- Wrap-around: rrPtr = 7 after serving column 6, with columns 7 and 0 both non-empty. Required response: column 7 is served, then column 0.
- Completion: all colDone = 1 and all FIFOs drained. Required response:
  - allDone = 1 one edge after the last accept.
  - allDone = 0 while any FIFO is non-empty or a move is pending.
- Reset mid-PRESENT: assert reset with moveValid = 1. Required response:
  - Next cycle moveValid = 0, moveCount = 0, allDone = 0, colRden = 0.
  - The search restarts from column 0.
